// File: rtl/exe_muldiv_ctrl_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 encodings, FSM states, special-case constants and a pre-shift helper.
package exe_muldiv_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  // Leading-zero count capped at 31 so a zero dividend still gets one iteration.
  function automatic logic [4:0] lead_shift(input logic [XLEN-1:0] v);
    logic [4:0] n;
    n = 5'd31;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/exe_muldiv_ctrl_if.sv
// Execution-stage handshake between the pipeline and the multiply/divide sequencer.
interface exe_muldiv_ctrl_if;
  logic                                 start_i;
  logic [2:0]                           funct3_i;
  logic [exe_muldiv_ctrl_pkg::XLEN-1:0] dat_a_i;
  logic [exe_muldiv_ctrl_pkg::XLEN-1:0] dat_b_i;
  logic                                 kill_i;
  logic                                 stall_o;
  logic                                 done_o;
  logic [exe_muldiv_ctrl_pkg::XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, dat_a_i, dat_b_i, kill_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, dat_a_i, dat_b_i, kill_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/exe_muldiv_ctrl_muldiv_datapath.sv
// Shift-add multiplier and restoring divider registers; the *_o results are the
// post-step values with the requested sign applied, ready to latch on the final step.
module muldiv_datapath
  import exe_muldiv_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic            step,
  input  logic            div,
  input  logic            neg_res,
  input  logic            neg_rem,
  input  logic [4:0]      shamt,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [63:0]     prod,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            mplier_last
);

  logic [63:0]     acc, mcand, acc_nxt;
  logic [XLEN-1:0] mplier, pr, dq, dvsr, pr_nxt, dq_nxt;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    acc_nxt = mplier[0] ? acc + mcand : acc;
    shifted = {pr, dq[XLEN-1]};
    ge      = shifted >= {1'b0, dvsr};
    pr_nxt  = ge ? 32'(shifted - {1'b0, dvsr}) : shifted[XLEN-1:0];
    dq_nxt  = {dq[XLEN-2:0], ge};
  end

  assign prod        = neg_res ? -acc_nxt : acc_nxt;
  assign quo         = neg_res ? -dq_nxt  : dq_nxt;
  assign rem         = neg_rem ? -pr_nxt  : pr_nxt;
  assign mplier_last = (mplier[XLEN-1:1] == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      pr     <= '0;
      dq     <= '0;
      dvsr   <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {32'b0, a_mag};
      mplier <= b_mag;
      pr     <= '0;
      dq     <= a_mag << shamt;
      dvsr   <= b_mag;
    end else if (step) begin
      if (div) begin
        pr <= pr_nxt;
        dq <= dq_nxt;
      end else begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// RV32M multiply/divide sequencer: FSM, iteration counter and special-case handling.
// Optional MULDIV_EARLY_OUT_EN shortens multiply/divide iteration counts.
module exe_muldiv_ctrl
  import exe_muldiv_ctrl_pkg::*;
(
  input logic               clk_i,
  input logic               rst_i,
  exe_muldiv_ctrl_if.slave  mdu
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  state_t          state;
  logic [4:0]      cnt, shamt;
  logic [2:0]      op;
  logic            neg_res, neg_rem, done_q;
  logic [XLEN-1:0] result_q, a_mag, b_mag, special_res, fin_res, quo, rem;
  logic [63:0]     prod;
  logic            a_sgn, b_sgn, a_neg, b_neg, in_div, div_zero, ovf, special;
  logic            accept, busy, step, last, mplier_last;

  always_comb begin
    in_div   = mdu.funct3_i[2];
    a_sgn    = mdu.funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_sgn    = mdu.funct3_i inside {F3_MULH, F3_DIV, F3_REM};
    a_neg    = a_sgn & mdu.dat_a_i[XLEN-1];
    b_neg    = b_sgn & mdu.dat_b_i[XLEN-1];
    a_mag    = a_neg ? -mdu.dat_a_i : mdu.dat_a_i;
    b_mag    = b_neg ? -mdu.dat_b_i : mdu.dat_b_i;
    div_zero = in_div & (mdu.dat_b_i == '0);
    ovf      = in_div & ~mdu.funct3_i[0] & (mdu.dat_a_i == INT_MIN) & (mdu.dat_b_i == ALL_ONES);
    special  = div_zero | ovf;
    if (div_zero) special_res = mdu.funct3_i[1] ? mdu.dat_a_i : ALL_ONES;
    else          special_res = mdu.funct3_i[1] ? '0 : INT_MIN;
    shamt    = (EARLY_EN && in_div) ? lead_shift(a_mag) : 5'd0;
  end

  assign accept = (state == ST_IDLE) & mdu.start_i & ~mdu.kill_i;
  assign busy   = (state == ST_MUL) | (state == ST_DIV);
  assign step   = busy & ~mdu.kill_i;
  assign last   = (cnt == 5'd31) | (EARLY_EN & (state == ST_MUL) & mplier_last);

  always_comb begin
    if (!op[2]) fin_res = (op == F3_MUL) ? prod[31:0] : prod[63:32];
    else        fin_res = op[1] ? rem : quo;
  end

  muldiv_datapath u_datapath (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load        (accept & ~special),
    .step        (step),
    .div         (state == ST_DIV),
    .neg_res     (neg_res),
    .neg_rem     (neg_rem),
    .shamt       (shamt),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .prod        (prod),
    .quo         (quo),
    .rem         (rem),
    .mplier_last (mplier_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op       <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (mdu.kill_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (mdu.start_i) begin
            op      <= mdu.funct3_i;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= shamt;
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= in_div ? ST_DIV : ST_MUL;
            end
          end
          ST_MUL, ST_DIV: begin
            cnt <= cnt + 5'd1;
            if (last) begin
              result_q <= fin_res;
              done_q   <= 1'b1;
              state    <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mdu.stall_o  = accept | busy;
  assign mdu.done_o   = done_q;
  assign mdu.result_o = result_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Randomized self-checking bench for exe_muldiv_ctrl against an arithmetic RV32M model.
module tb_exe_muldiv_ctrl;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_muldiv_ctrl_if mif();

  exe_muldiv_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .mdu   (mif)
  );

  int          checks   = 0;
  int          failures = 0;
  bit          busy     = 1'b0;
  logic [31:0] last_exp = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == MIN32) && (b == 32'hFFFF_FFFF);
    case (f)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN32 : 32'(ia / ib);
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      OP_REMU: return (b == 0) ? a : a % b;
      default: begin
        sa = (f == OP_MULH || f == OP_MULHSU) ? longint'(ia) : longint'({32'b0, a});
        sb = (f == OP_MULH) ? longint'(ib) : longint'({32'b0, b});
        p  = 64'(sa * sb);
        return (f == OP_MUL) ? p[31:0] : p[63:32];
      end
    endcase
  endfunction

  function automatic int bit_length(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Cycles from the accept cycle to the done_o cycle.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    if (f[2] && (b == 0 || (!f[0] && a == MIN32 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2]) m = (!f[0] && a[31]) ? -a : a;
    else      m = (f == OP_MULH && b[31]) ? -b : b;
    return 1 + ((m == 0) ? 1 : bit_length(m));
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN32;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Caller is at a negedge with the sequencer idle; returns at the negedge after done_o.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          lat, k;
    bit          stall_ok;
    exp = ref_result(f, a, b);
    lat = ref_latency(f, a, b);
    mif.start_i  = 1'b1;
    mif.funct3_i = f;
    mif.dat_a_i  = a;
    mif.dat_b_i  = b;
    #1;
    check_eq({tag, "_stall_accept"}, 32'(mif.stall_o), 32'd1);
    @(negedge clk);
    busy         = 1'b1;
    mif.start_i  = 1'b0;
    mif.dat_a_i  = $urandom;
    mif.dat_b_i  = $urandom;
    k        = 1;
    stall_ok = 1'b1;
    while (!mif.done_o && k < 40) begin
      if (!mif.stall_o) stall_ok = 1'b0;
      if (mif.result_o !== last_exp) stall_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    busy = 1'b0;
    check_eq({tag, "_latency"}, 32'(k), 32'(lat));
    check_eq({tag, "_result"}, mif.result_o, exp);
    check_eq({tag, "_busy_stall_hold"}, 32'(stall_ok), 32'd1);
    check_eq({tag, "_stall_done"}, 32'(mif.stall_o), 32'd0);
    last_exp = exp;
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(mif.done_o), 32'd0);
  endtask

  // Starts a DIV and leaves the bench at the negedge of iteration 10.
  task automatic start_div_to_iter10();
    mif.start_i  = 1'b1;
    mif.funct3_i = OP_DIV;
    mif.dat_a_i  = 32'd1000;
    mif.dat_b_i  = 32'd3;
    @(negedge clk);
    busy        = 1'b1;
    mif.start_i = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (mif.start_i) assert (!busy && !mif.done_o) else $error("start_i driven outside IDLE");
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  op_t dir[$];
  bit  seen;

  initial begin
    mif.start_i  = 1'b0;
    mif.funct3_i = '0;
    mif.dat_a_i  = '0;
    mif.dat_b_i  = '0;
    mif.kill_i   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_stall", 32'(mif.stall_o), 32'd0);
    check_eq("reset_done", 32'(mif.done_o), 32'd0);
    check_eq("reset_result", mif.result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    dir = '{
      '{OP_MUL,    32'd7,        32'hFFFF_FFFD},
      '{OP_MULH,   MIN32,        MIN32},
      '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{OP_DIV,    32'hFFFF_FFF9, 32'd2},
      '{OP_REM,    32'hFFFF_FFF9, 32'd2},
      '{OP_DIVU,   32'd100,      32'd7},
      '{OP_REMU,   32'd100,      32'd7},
      '{OP_DIVU,   32'd100,      32'd0},
      '{OP_REM,    32'd100,      32'd0},
      '{OP_DIV,    MIN32,        32'hFFFF_FFFF},
      '{OP_REM,    MIN32,        32'hFFFF_FFFF},
      '{OP_MUL,    32'd5,        32'd3}
    };
    foreach (dir[i]) run_op($sformatf("dir%0d", i), dir[i].f, dir[i].a, dir[i].b);

    // kill mid-divide: no done_o, result holds
    start_div_to_iter10();
    mif.kill_i = 1'b1;
    @(negedge clk);
    mif.kill_i = 1'b0;
    busy = 1'b0;
    check_eq("kill_stall", 32'(mif.stall_o), 32'd0);
    check_eq("kill_done", 32'(mif.done_o), 32'd0);
    check_eq("kill_result", mif.result_o, last_exp);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mif.done_o) seen = 1'b1;
    end
    check_eq("kill_no_late_done", 32'(seen), 32'd0);

    // kill in the same cycle as start blocks the accept
    mif.start_i  = 1'b1;
    mif.kill_i   = 1'b1;
    mif.funct3_i = OP_MUL;
    #1;
    check_eq("kill_start_stall", 32'(mif.stall_o), 32'd0);
    @(negedge clk);
    mif.start_i = 1'b0;
    mif.kill_i  = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (mif.done_o || mif.stall_o) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("kill_start_idle", 32'(seen), 32'd0);
    run_op("after_kill_mul", OP_MUL, 32'd3, 32'd5);

    // asynchronous reset mid-divide
    start_div_to_iter10();
    #2 rst = 1'b1;
    #1;
    busy = 1'b0;
    check_eq("rst_mid_stall", 32'(mif.stall_o), 32'd0);
    check_eq("rst_mid_done", 32'(mif.done_o), 32'd0);
    check_eq("rst_mid_result", mif.result_o, 32'd0);
    last_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst_mul", OP_MUL, 32'd3, 32'd5);

    for (int i = 0; i < 300; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
